pixel_scheduler: RTL

Sequencing front end for the ray-tracing render lanes. On a start pulse it walks the image raster (x fastest, then y) and issues one pixel job per cycle round-robin across `NUM_LANES` render lanes. It collects their 32-bit fragments in the same round-robin order, so the outgoing AXI-Stream carries pixels in raster order with `tlast` on the final pixel. It sits between the coprocessor's scene/config logic and the AXIS master port, replacing the single-core direct hookup.

---
 rtl/raytracer_pkg.sv | 13 +
 rtl/raster_walker.sv | 35 +++
 rtl/pixel_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/raytracer_pkg.sv
// Shared types for the render-lane front end: fragment word, coordinate width default,
// and the pixel scheduler state encoding.
package raytracer_pkg;
  localparam int COORD_W_DEF = 16;

  typedef logic [31:0] fragment_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } sched_state_e;
endpackage

// File: rtl/raster_walker.sv
// Raster coordinate generator: x fastest, then y. Raises issued_all once the
// last pixel of the frame has been handed out.
module raster_walker #(
  parameter int COORD_W = 16
) (
  input  logic               aclk,
  input  logic               resetn,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               load,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               issued_all
);
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      x          <= '0;
      y          <= '0;
      issued_all <= 1'b0;
    end else if (load) begin
      x          <= '0;
      y          <= '0;
      issued_all <= 1'b0;
    end else if (advance && !issued_all) begin
      if (x == width - 1'b1) begin
        x <= '0;
        y <= y + 1'b1;
        if (y == height - 1'b1) issued_all <= 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pixel_scheduler.sv
// Round-robin pixel job issue and in-order fragment collection onto AXI-Stream.
// Optional performance counters under `PIXEL_SCHED_PERF_EN.
module pixel_scheduler
  import raytracer_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int COORD_W   = COORD_W_DEF
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [COORD_W-1:0]     image_width,
  input  logic [COORD_W-1:0]     image_height,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_LANES-1:0]   job_valid,
  input  logic [NUM_LANES-1:0]   job_ready,
  output logic [COORD_W-1:0]     job_x,
  output logic [COORD_W-1:0]     job_y,
  input  logic [NUM_LANES-1:0]   res_valid,
  output logic [NUM_LANES-1:0]   res_ready,
  input  logic [NUM_LANES*32-1:0] res_data,
  output logic                   m_axis_tvalid,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
`ifdef PIXEL_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_frame_cycles,
  output logic [31:0]            perf_stall_cycles
`endif
);
  localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int TW = 2 * COORD_W;

  sched_state_e state, state_nxt;

  logic [COORD_W-1:0] width_q, height_q, x, y;
  logic               issued_all;
  logic [PW-1:0]      issue_ptr, collect_ptr;
  logic [TW-1:0]      total, out_cnt;
  logic [NUM_LANES-1:0][31:0] res_lanes;
  fragment_t          sel_frag;
  logic               start_ok, running, issue_fire, collect_en, collect_fire, last_fire;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(NUM_LANES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign res_lanes    = res_data;
  assign sel_frag     = res_lanes[collect_ptr];
  assign start_ok     = (state == IDLE) && start;
  assign running      = (state == RUN);
  assign issue_fire   = running && !issued_all && job_ready[issue_ptr];
  // Collection stops once every beat of the frame is in the output register.
  assign collect_en   = running && (out_cnt != total) && (!m_axis_tvalid || m_axis_tready);
  assign collect_fire = collect_en && res_valid[collect_ptr];
  assign last_fire    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  assign busy  = running;
  assign job_x = x;
  assign job_y = y;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign job_valid[i] = running && !issued_all && (issue_ptr == PW'(i));
    assign res_ready[i] = collect_en && (collect_ptr == PW'(i));
  end

  raster_walker #(.COORD_W(COORD_W)) u_walker (
    .aclk       (aclk),
    .resetn     (resetn),
    .width      (width_q),
    .height     (height_q),
    .load       (start_ok),
    .advance    (issue_fire),
    .x          (x),
    .y          (y),
    .issued_all (issued_all)
  );

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (image_width == '0 || image_height == '0) ? FINISH : RUN;
      RUN:     if (last_fire) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      done          <= 1'b0;
      width_q       <= '0;
      height_q      <= '0;
      total         <= '0;
      out_cnt       <= '0;
      issue_ptr     <= '0;
      collect_ptr   <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (start_ok) begin
        width_q     <= image_width;
        height_q    <= image_height;
        total       <= TW'(image_width) * TW'(image_height);
        out_cnt     <= '0;
        issue_ptr   <= '0;
        collect_ptr <= '0;
      end else begin
        if (issue_fire) issue_ptr <= ptr_next(issue_ptr);
        if (collect_fire) begin
          collect_ptr <= ptr_next(collect_ptr);
          out_cnt     <= out_cnt + 1'b1;
        end
      end
      // Reload and drain may coincide, giving one beat per cycle.
      if (collect_fire) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_frag;
        m_axis_tlast  <= (out_cnt == total - 1'b1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

`ifdef PIXEL_SCHED_PERF_EN
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      perf_frame_cycles <= '0;
      perf_stall_cycles <= '0;
    end else if (start_ok) begin
      perf_frame_cycles <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (running && !(&perf_frame_cycles)) perf_frame_cycles <= perf_frame_cycles + 1'b1;
      if (m_axis_tvalid && !m_axis_tready && !(&perf_stall_cycles))
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif
endmodule
